// File: rtl/maxterm_extractor.sv
// Truth-table sweeper: drives every stim value, samples s/control and recovers their maxterm masks.
// Optional build macro MAXTERM_EXTRACTOR_STOP_ON_MISMATCH_EN ends the sweep at the first disagreement.
module maxterm_extractor #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                s,
    input  logic                control,
    output logic [N-1:0]        stim,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   mask_s,
    output logic [(1<<N)-1:0]   mask_c,
    output logic [N:0]          count_s,
    output logic                mismatch,
    output logic [N-1:0]        first_bad
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       first_fail;
    logic       last_index;
    logic       stop_now;

    // Only the first disagreement is recorded; later ones leave first_bad untouched.
    assign first_fail = (s != control) && !mismatch;
    assign last_index = &stim;

`ifdef MAXTERM_EXTRACTOR_STOP_ON_MISMATCH_EN
    assign stop_now = first_fail || last_index;
`else
    assign stop_now = last_index;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mask_s    <= '0;
            mask_c    <= '0;
            count_s   <= '0;
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_s    <= '0;
                        mask_c    <= '0;
                        count_s   <= '0;
                        mismatch  <= 1'b0;
                        first_bad <= '0;
                        stim      <= '0;
                        cnt       <= 4'(SETTLE);
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end

                RUN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mask_s[stim] <= ~s;
                        mask_c[stim] <= ~control;
                        if (!s) begin
                            count_s <= count_s + (N+1)'(1);
                        end
                        if (first_fail) begin
                            mismatch  <= 1'b1;
                            first_bad <= stim;
                        end
                        // stim is held on exit so it reports the last sampled index.
                        if (stop_now) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            stim <= stim + N'(1);
                            cnt  <= 4'(SETTLE);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
